// File: rtl/param_regfile.sv
// ---------------------------------------------------------------------------
// param_regfile
//
// Register file with 2**ADDR_W entries of DATA_W bits and two registered
// read ports. Writes commit only in the execute phase (pst == EXEC_STATE)
// and only when the ALU result is usable (no overflow/underflow), the
// target is not address 0, and no reinitialisation sweep is running.
// A blocked write attempt raises write_rejected for one cycle.
//
// A reinitialisation sweep writes entry[i] = i (truncated to DATA_W) to
// every entry, one per cycle. It runs after reset and whenever clear_req
// is seen while idle. While it runs, busy is high, both read ports
// output 0 and all writes are rejected.
//
// Optional build macro:
//   REGFILE_BYPASS_EN - a read that samples the address being written at
//                       the same edge returns the new data instead of the
//                       old contents. Address 0 still reads as 0.
//
// Ports:
//   clk            clock
//   rst            reset, asynchronous, active-high (starts a sweep)
//   pst            current processor phase
//   reg_write      write request from control
//   rd1_addr       read port 1 address
//   rd2_addr       read port 2 address
//   wr_addr        write address
//   wr_data        write data (ALU result)
//   overflow       ALU overflow flag (blocks the write)
//   underflow      ALU underflow flag (blocks the write)
//   clear_req      request a full reinitialisation sweep
//   read_data1     registered read port 1
//   read_data2     registered read port 2
//   busy           high while the sweep runs
//   write_rejected one-cycle pulse after a blocked write attempt
// ---------------------------------------------------------------------------
module param_regfile #(
    parameter int               DATA_W     = 4,
    parameter int               ADDR_W     = 4,
    parameter int               PST_W      = 4,
    parameter logic [PST_W-1:0] EXEC_STATE = 4'b1110
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PST_W-1:0]  pst,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              overflow,
    input  logic              underflow,
    input  logic              clear_req,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              busy,
    output logic              write_rejected
);

    localparam int               DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   read_data1_q, read_data1_d;
    logic [DATA_W-1:0]   read_data2_q, read_data2_d;
    logic                write_rejected_q, write_rejected_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    // -----------------------------------------------------------------------
    // Write qualification
    // -----------------------------------------------------------------------
    logic                write_attempt;
    logic                write_commit;
    logic                sweeping;

    assign sweeping      = (state_q == ST_SWEEP);
    assign write_attempt = (pst == EXEC_STATE) && reg_write;
    assign write_commit  = write_attempt && (wr_addr != '0) &&
                           !overflow && !underflow && !sweeping;

    // Single memory write port: the sweep and a committed write never
    // coincide because commits are blocked while sweeping.
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (sweeping) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = DATA_W'(cnt_q);
        end else if (write_commit) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Sweep FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // A write in this same cycle still commits; the sweep
                // begins at the following cycle.
                if (clear_req) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            ST_SWEEP: begin
                // clear_req is deliberately ignored here so a running
                // sweep is never restarted.
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Read ports and reject pulse
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] rd1_val;
    logic [DATA_W-1:0] rd2_val;

    always_comb begin
        rd1_val = mem_q[rd1_addr];
        rd2_val = mem_q[rd2_addr];
`ifdef REGFILE_BYPASS_EN
        if (write_commit && (wr_addr == rd1_addr)) rd1_val = wr_data;
        if (write_commit && (wr_addr == rd2_addr)) rd2_val = wr_data;
`endif
        // Address 0 is hard-wired to zero regardless of storage.
        if (rd1_addr == '0) rd1_val = '0;
        if (rd2_addr == '0) rd2_val = '0;

        // Outputs are registered, so zero them whenever the cycle after
        // this edge belongs to a sweep.
        read_data1_d = (state_d == ST_SWEEP) ? '0 : rd1_val;
        read_data2_d = (state_d == ST_SWEEP) ? '0 : rd2_val;

        write_rejected_d = write_attempt && !write_commit;
    end

    // -----------------------------------------------------------------------
    // FSM and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_SWEEP;
            cnt_q            <= '0;
            read_data1_q     <= '0;
            read_data2_q     <= '0;
            write_rejected_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            read_data1_q     <= read_data1_d;
            read_data2_q     <= read_data2_d;
            write_rejected_q <= write_rejected_d;
        end
    end

    // Storage has no reset; the post-reset sweep initialises every entry.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign read_data1     = read_data1_q;
    assign read_data2     = read_data2_q;
    assign busy           = sweeping;
    assign write_rejected = write_rejected_q;

endmodule

// File: tb/tb_param_regfile.sv
module tb_param_regfile;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam logic [3:0] EXEC = 4'b1110;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [3:0]    pst;
  logic          reg_write;
  logic [AW-1:0] rd1_addr;
  logic [AW-1:0] rd2_addr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          overflow;
  logic          underflow;
  logic          clear_req;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;
  logic          busy;
  logic          write_rejected;

  int vectors = 0;
  int miscompares = 0;

  // reference model: entry contents plus remaining sweep length
  int model_mem[DEPTH];
  int sweep_left;
  int sweep_idx;

  param_regfile dut (
    .clk(clk), .rst(rst), .pst(pst), .reg_write(reg_write),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .wr_addr(wr_addr),
    .wr_data(wr_data), .overflow(overflow), .underflow(underflow),
    .clear_req(clear_req), .read_data1(read_data1), .read_data2(read_data2),
    .busy(busy), .write_rejected(write_rejected)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock of stimulus, then compare all outputs with the model
  task automatic step(input logic [3:0] p, input logic rw, input logic [3:0] wa,
                      input logic [3:0] wd, input logic ov, input logic uf,
                      input logic clr, input logic [3:0] ra1, input logic [3:0] ra2,
                      input string tag);
    bit busy_b;
    bit attempt;
    bit commit;
    int v1;
    int v2;
    pst = p; reg_write = rw; wr_addr = wa; wr_data = wd;
    overflow = ov; underflow = uf; clear_req = clr;
    rd1_addr = ra1; rd2_addr = ra2;
    busy_b  = (sweep_left > 0);
    attempt = (p == EXEC) && rw;
    commit  = attempt && (wa != 0) && !ov && !uf && !busy_b;
    v1 = (ra1 == 0) ? 0 : ((BYP && commit && wa == ra1) ? int'(wd) : model_mem[ra1]);
    v2 = (ra2 == 0) ? 0 : ((BYP && commit && wa == ra2) ? int'(wd) : model_mem[ra2]);
    @(posedge clk);
    @(negedge clk);
    if (commit) model_mem[wa] = wd;
    if (busy_b) begin
      model_mem[sweep_idx] = sweep_idx % (1 << DW);
      sweep_idx++;
      sweep_left--;
    end else if (clr) begin
      sweep_left = DEPTH;
      sweep_idx = 0;
    end
    if (sweep_left > 0) begin
      v1 = 0;
      v2 = 0;
    end
    check({tag, ".rd1"}, read_data1, v1);
    check({tag, ".rd2"}, read_data2, v2);
    check({tag, ".busy"}, busy, (sweep_left > 0));
    check({tag, ".rej"}, write_rejected, attempt && !commit);
  endtask

  task automatic idle_read(input logic [3:0] ra1, input logic [3:0] ra2, input string tag);
    step(4'b0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, ra1, ra2, tag);
  endtask

  task automatic exec_write(input logic [3:0] wa, input logic [3:0] wd, input logic ov,
                            input logic uf, input logic clr, input logic [3:0] ra1,
                            input string tag);
    step(EXEC, 1'b1, wa, wd, ov, uf, clr, ra1, 4'd0, tag);
  endtask

  // sweep cycles with random reads and write attempts; addresses kept below
  // the last entry so the final sweep edge never reads a not-yet-written word
  task automatic sweep_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(($urandom_range(0, 1) == 1) ? EXEC : 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'b0, 1'b0, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)), tag);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
    rst = 1'b0; pst = '0; reg_write = 1'b0; rd1_addr = '0; rd2_addr = '0;
    wr_addr = '0; wr_data = '0; overflow = 1'b0; underflow = 1'b0; clear_req = 1'b0;

    // asynchronous reset, checked before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst.busy", busy, 1);
    check("rst.rd1", read_data1, 0);
    check("rst.rd2", read_data2, 0);
    check("rst.rej", write_rejected, 0);
    sweep_left = DEPTH;
    sweep_idx = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // post-reset sweep: 16 cycles busy, then index values readable
    sweep_steps(DEPTH, "init_sweep");
    idle_read(4'd1, 4'd13, "read_1_13");
    check("init.busy_low", busy, 0);

    // execute-phase write commits; wrong phase does not
    exec_write(4'd5, 4'd9, 1'b0, 1'b0, 1'b0, 4'd5, "wr5");
    idle_read(4'd5, 4'd6, "rd5");
    step(4'b0001, 1'b1, 4'd6, 4'd2, 1'b0, 1'b0, 1'b0, 4'd6, 4'd5, "wr6_wrong_pst");
    idle_read(4'd6, 4'd5, "rd6");

    // blocked writes: address 0, overflow, underflow
    exec_write(4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 4'd0, "wr0");
    exec_write(4'd3, 4'd11, 1'b1, 1'b0, 1'b0, 4'd3, "wr3_ovf");
    exec_write(4'd2, 4'd12, 1'b0, 1'b1, 1'b0, 4'd2, "wr2_udf");
    idle_read(4'd0, 4'd3, "rd0_3");
    idle_read(4'd2, 4'd1, "rd2_1");

    // clear with a simultaneous write: write commits, sweep follows
    exec_write(4'd7, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0, "wr7");
    idle_read(4'd7, 4'd0, "rd7_pre");
    exec_write(4'd8, 4'd3, 1'b0, 1'b0, 1'b1, 4'd8, "wr8_clr");
    sweep_steps(DEPTH, "clr_sweep");
    idle_read(4'd7, 4'd8, "rd7_8_post");

    // same-edge read of the write address, then one cycle later
    exec_write(4'd4, 4'd6, 1'b0, 1'b0, 1'b0, 4'd4, "wr4_bypass");
    idle_read(4'd4, 4'd4, "rd4_after");

    // reset in the middle of a sweep restarts it from entry 0
    idle_read(4'd1, 4'd2, "pre_clr");
    step(4'b0000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, "clr2");
    sweep_steps(4, "part_sweep");
    exec_write(4'd9, 4'd1, 1'b0, 1'b0, 1'b0, 4'd9, "busy_wr");
    #2 rst = 1'b1;
    #1;
    check("mid_rst.busy", busy, 1);
    check("mid_rst.rej", write_rejected, 0);
    check("mid_rst.rd1", read_data1, 0);
    sweep_left = DEPTH;
    sweep_idx = 0;
    @(negedge clk);
    rst = 1'b0;
    sweep_steps(DEPTH, "restart_sweep");
    check("restart.busy_low", busy, 0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 1) == 1) ? EXEC : 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 39) == 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
